video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parameterised video timing and test-pattern source: it generates `vsync`, `hsync`, `de` and 10-bit RGB pixel data frame by frame. It sits directly upstream of `scaler_top` and drives its `i_vsync`/`i_hsync`/`i_de`/`i_*_data` inputs. It replaces task-based stimulus with synthesizable RTL usable both on the bench and on the board.

## Interface
- `VSYNC_POL`, 0: 0 = vsync active high, 1 = active low
- `HSYNC_POL`, 0: 0 = hsync active high, 1 = active low
- `VSW`, 1: vertical sync width [lines]
- `VBP`, 1: vertical back porch [lines]
- `VACT`, 4: vertical active [lines]
- `VFP`, 1: vertical front porch [lines]
- `HSW`, 1: horizontal sync width [clocks]
- `HBP`, 2: horizontal back porch [clocks]
- `HACT`, 10: horizontal active [clocks]
- `HFP`, 2: horizontal front porch [clocks]
- `VTOT`/`HTOT`: derived sums, not overridden
- `clk` in 1: pixel clock
- `rstn` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_en` in 1: run request, level-sensitive
- `i_pat_sel` in 2: 0 colour bars, 1 ramp, 2 checkerboard, 3 solid
- `i_solid_rgb` in 30: {R,G,B} used for pattern 3
- `o_vsync` out 1: vertical sync, polarity per `VSYNC_POL`
- `o_hsync` out 1: horizontal sync, polarity per `HSYNC_POL`
- `o_de` out 1: data enable
- `o_r_data`, `o_g_data`, `o_b_data` out 10 each: pixel data, 0 when `o_de`=0
- `o_busy` out 1: high while a frame is in progress
- `o_frame_cnt` out 16: completed frames, wraps at 0xFFFF→0

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN: on a clock edge that samples `i_en`=1. That same edge loads h=0, v=0 and latches `i_pat_sel`/`i_solid_rgb` for the frame.
- Counters in RUN:
  - h counts 0..HTOT-1, then wraps to 0.
  - v increments on each h wrap.
  - The last pixel of a frame is at h=HTOT-1, v=VTOT-1.
- At the last pixel:
  - `o_frame_cnt` increments.
  - If `i_en`=1, h/v go to 0, the pattern is re-latched, and the next frame continues seamlessly.
  - Otherwise the FSM goes to IDLE.
- Dropping `i_en` mid-frame never truncates a frame.
- Horizontal regions: SW h<HSW; BP h<HSW+HBP; ACT h<HSW+HBP+HACT; else FP. Vertical regions use the same scheme on v.
- Signal generation:
  - Sync is active for the whole line when v is in SW.
  - hsync is active when h is in SW, on every line including vertical blanking.
  - de = (h in ACT) && (v in ACT).
  - Pixel x = h-HSW-HBP and y = v-VSW-VBP, both valid only while de=1.
- Patterns (full = 0x3FF):
  - Colour bars: BW = HACT/8 (integer division, minimum 1); index = min(x/BW, 7), computed with a bar counter, not a divider. Sequence 0..7 is white, yellow, cyan, green, magenta, red, blue, black; each channel is full or 0.
  - Ramp: R=G=B = x[9:0].
  - Checkerboard: all channels full when x[3]^y[3]=1, else 0.
  - Solid: channels equal the latched `i_solid_rgb`.
- Idle / reset output values: sync at inactive level, `o_de`=0, data=0, `o_busy`=0, `o_frame_cnt`=0.
- Async reset, including mid-frame, forces all outputs to these values immediately and the FSM to IDLE.

## Timing
- All outputs are registered.
- Position (h,v) is presented one clock after the counters hold it.
- The first frame pixel (0,0) appears at the second edge after `i_en` is sampled high.
- `o_busy` rises together with that first output.
- Frame period is exactly HTOT·VTOT clocks; there are no gap cycles between back-to-back frames.
- `o_frame_cnt` updates on the same edge that outputs the last pixel of the frame.
- `o_busy` falls one clock after the last pixel is output, when not continuing.
- Pattern changes take effect only at a frame boundary.

## Structure
- Package `video_pkg`:
  - `state_t` enum (IDLE, RUN).
  - `pat_t` enum (PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_SOLID).
  - `PIX_MAX` = 10'h3FF.
  - 8-entry colour-bar RGB constant array.
- Sub-module `video_pattern_gen`: combinational map from (x, y, bar index, pattern, solid) to RGB. The top level owns the FSM, counters, bar counter and output registers.

## Test plan
Use default parameters (HTOT=15, VTOT=7, 105 clocks per frame).
- Reset then hold `i_en`=1 for 3 frames → each frame has exactly 105 clocks. Per frame: hsync active 7 pulses × 1 clock, vsync active 15 consecutive clocks, de active 40 clocks (4 lines × 10). `o_frame_cnt` reaches 3.
- Pattern 0 → each active line carries white, yellow, cyan, green, magenta, red, blue, then black for x=7..9. Pattern 1 → R=G=B=0..9.
- Pattern 3 with `i_solid_rgb`={10'h155, 10'h2AA, 10'h3FF} → every de pixel equals that value, and data is 0 whenever de=0.
- Drop `i_en` at clock 50 of frame 1 → the frame completes all 105 clocks, `o_busy` falls, and outputs return to idle values.
- `VSYNC_POL`=1, `HSYNC_POL`=1 → sync waveforms are inverted and idle levels are 1.
- Assert `rstn`=0 mid-active line → all outputs go to idle values before the next edge. Re-enable → the frame restarts at (0,0) and `o_frame_cnt` restarts at 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video timing / test-pattern source.
package video_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_SOLID} pat_t;

    localparam logic [9:0] PIX_MAX = 10'h3FF;

    // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [29:0] BAR_RGB [8] = '{
        {PIX_MAX, PIX_MAX, PIX_MAX},
        {PIX_MAX, PIX_MAX, 10'h000},
        {10'h000, PIX_MAX, PIX_MAX},
        {10'h000, PIX_MAX, 10'h000},
        {PIX_MAX, 10'h000, PIX_MAX},
        {PIX_MAX, 10'h000, 10'h000},
        {10'h000, 10'h000, PIX_MAX},
        {10'h000, 10'h000, 10'h000}
    };

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern lookup: pixel position / bar index / pattern -> 30-bit RGB.
module video_pattern_gen
    import video_pkg::*;
(
    input  logic [1:0]  i_pat,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic [2:0]  i_bar_idx,
    input  logic [29:0] i_solid,
    output logic [29:0] o_rgb
);

    always_comb begin
        o_rgb = '0;
        case (pat_t'(i_pat))
            PAT_BARS:  o_rgb = BAR_RGB[i_bar_idx];
            PAT_RAMP:  o_rgb = {i_x, i_x, i_x};
            PAT_CHECK: o_rgb = (i_x[3] ^ i_y[3]) ? {PIX_MAX, PIX_MAX, PIX_MAX} : '0;
            PAT_SOLID: o_rgb = i_solid;
            default:   o_rgb = '0;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Frame timing generator: h/v counters, region decode, colour-bar counter and registered
// sync/de/RGB outputs, running frame after frame while i_en is held.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSW       = 1,
    parameter int unsigned VBP       = 1,
    parameter int unsigned VACT      = 4,
    parameter int unsigned VFP       = 1,
    parameter int unsigned HSW       = 1,
    parameter int unsigned HBP       = 2,
    parameter int unsigned HACT      = 10,
    parameter int unsigned HFP       = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_en,
    input  logic [1:0]  i_pat_sel,
    input  logic [29:0] i_solid_rgb,
    output logic        o_vsync,
    output logic        o_hsync,
    output logic        o_de,
    output logic [9:0]  o_r_data,
    output logic [9:0]  o_g_data,
    output logic [9:0]  o_b_data,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned VTOT = VSW + VBP + VACT + VFP;
    localparam int unsigned HTOT = HSW + HBP + HACT + HFP;
    localparam int unsigned CW   = 16;
    localparam int unsigned BW   = (HACT / 8 == 0) ? 1 : HACT / 8;

    localparam logic [CW-1:0] H_LAST  = CW'(HTOT - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(VTOT - 1);
    localparam logic [CW-1:0] H_SW_E  = CW'(HSW);
    localparam logic [CW-1:0] H_ACT_S = CW'(HSW + HBP);
    localparam logic [CW-1:0] H_ACT_E = CW'(HSW + HBP + HACT);
    localparam logic [CW-1:0] V_SW_E  = CW'(VSW);
    localparam logic [CW-1:0] V_ACT_S = CW'(VSW + VBP);
    localparam logic [CW-1:0] V_ACT_E = CW'(VSW + VBP + VACT);
    localparam logic [CW-1:0] BW_M1   = CW'(BW - 1);
    localparam logic          VS_IDLE = (VSYNC_POL != 0);
    localparam logic          HS_IDLE = (HSYNC_POL != 0);

    state_t        state_q;
    logic [CW-1:0] h_q, v_q, h_nxt, v_nxt;
    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    pat_q;
    logic [29:0]   solid_q;

    logic          vsync_q, hsync_q, de_q, busy_q;
    logic [29:0]   rgb_q, rgb_c;
    logic [15:0]   frame_cnt_q;

    logic h_sw, v_sw, h_act, v_act, de_c, last_pix;
    logic [9:0] pix_x, pix_y;

    assign h_sw     = (h_q < H_SW_E);
    assign v_sw     = (v_q < V_SW_E);
    assign h_act    = (h_q >= H_ACT_S) && (h_q < H_ACT_E);
    assign v_act    = (v_q >= V_ACT_S) && (v_q < V_ACT_E);
    assign de_c     = h_act && v_act;
    assign last_pix = (h_q == H_LAST) && (v_q == V_LAST);
    assign pix_x    = 10'(h_q - H_ACT_S);
    assign pix_y    = 10'(v_q - V_ACT_S);

    always_comb begin
        h_nxt = h_q + CW'(1);
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end
    end

    // Bar index tracks min(x/BW, 7) incrementally, restarted just before each active span.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (h_act) begin
            if (bar_cnt_q == BW_M1) begin
                bar_cnt_d = '0;
                if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + CW'(1);
            end
        end
        if (h_nxt == H_ACT_S) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end
    end

    video_pattern_gen u_pattern (
        .i_pat     (pat_q),
        .i_x       (pix_x),
        .i_y       (pix_y),
        .i_bar_idx (bar_idx_q),
        .i_solid   (solid_q),
        .o_rgb     (rgb_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            h_q         <= '0;
            v_q         <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            pat_q       <= PAT_BARS;
            solid_q     <= '0;
            vsync_q     <= VS_IDLE;
            hsync_q     <= HS_IDLE;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    vsync_q <= VS_IDLE;
                    hsync_q <= HS_IDLE;
                    de_q    <= 1'b0;
                    rgb_q   <= '0;
                    busy_q  <= 1'b0;
                    if (i_en) begin
                        state_q   <= RUN;
                        h_q       <= '0;
                        v_q       <= '0;
                        bar_cnt_q <= '0;
                        bar_idx_q <= '0;
                        pat_q     <= i_pat_sel;
                        solid_q   <= i_solid_rgb;
                    end
                end
                RUN: begin
                    vsync_q   <= v_sw ^ VS_IDLE;
                    hsync_q   <= h_sw ^ HS_IDLE;
                    de_q      <= de_c;
                    rgb_q     <= de_c ? rgb_c : '0;
                    busy_q    <= 1'b1;
                    h_q       <= h_nxt;
                    v_q       <= v_nxt;
                    bar_cnt_q <= bar_cnt_d;
                    bar_idx_q <= bar_idx_d;
                    if (last_pix) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        if (i_en) begin
                            pat_q   <= i_pat_sel;
                            solid_q <= i_solid_rgb;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_vsync     = vsync_q;
    assign o_hsync     = hsync_q;
    assign o_de        = de_q;
    assign o_r_data    = rgb_q[29:20];
    assign o_g_data    = rgb_q[19:10];
    assign o_b_data    = rgb_q[9:0];
    assign o_busy      = busy_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default and inverted-polarity instances against a frame-index model.
module tb_video_timing_gen;

    localparam int HSW = 1, HBP = 2, HACT = 10, HFP = 2;
    localparam int VSW = 1, VBP = 1, VACT = 4, VFP = 1;
    localparam int HTOT  = HSW + HBP + HACT + HFP;
    localparam int VTOT  = VSW + VBP + VACT + VFP;
    localparam int FRAME = HTOT * VTOT;
    localparam int BW    = (HACT / 8 < 1) ? 1 : HACT / 8;
    localparam int ACT0  = (VSW + VBP) * HTOT + HSW + HBP;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [29:0] solid = '0;

    logic        vs0, hs0, de0, busy0, vs1, hs1, de1, busy1;
    logic [9:0]  r0, g0, b0, r1, g1, b1;
    logic [15:0] fc0, fc1;

    int n_total = 0;
    int n_pass  = 0;

    logic [2:0]  bar_mask [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                  3'b101, 3'b100, 3'b001, 3'b000};
    logic [29:0] bar_line [10] = '{30'h3FFFFFFF, 30'h3FFFFC00, 30'h000FFFFF, 30'h000FFC00,
                                   30'h3FF003FF, 30'h3FF00000, 30'h000003FF, 30'h00000000,
                                   30'h00000000, 30'h00000000};

    // Reference model: frame position as a linear pixel index
    bit          m_run = 0;
    int          m_p = 0;
    int          m_pat = 0;
    logic [29:0] m_solid = '0;
    logic [15:0] m_cnt = '0;
    bit          m_vs = 0, m_hs = 0, m_de = 0, m_busy = 0;
    logic [29:0] m_rgb = '0;

    video_timing_gen u_dut0 (
        .clk(clk), .rstn(rstn), .i_en(en), .i_pat_sel(pat), .i_solid_rgb(solid),
        .o_vsync(vs0), .o_hsync(hs0), .o_de(de0), .o_r_data(r0), .o_g_data(g0),
        .o_b_data(b0), .o_busy(busy0), .o_frame_cnt(fc0)
    );

    video_timing_gen #(.VSYNC_POL(1), .HSYNC_POL(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_en(en), .i_pat_sel(pat), .i_solid_rgb(solid),
        .o_vsync(vs1), .o_hsync(hs1), .o_de(de1), .o_r_data(r1), .o_g_data(g1),
        .o_b_data(b1), .o_busy(busy1), .o_frame_cnt(fc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [29:0] ref_rgb(int x, int y, int p, logic [29:0] s);
        int b;
        logic [2:0] m;
        logic [9:0] xv;
        xv = x[9:0];
        case (p)
            0: begin
                b = x / BW;
                if (b > 7) b = 7;
                m = bar_mask[b];
                return {{10{m[2]}}, {10{m[1]}}, {10{m[0]}}};
            end
            1: return {xv, xv, xv};
            2: return ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? {30{1'b1}} : 30'h0;
            default: return s;
        endcase
    endfunction

    task automatic model_idle();
        m_vs = 0; m_hs = 0; m_de = 0; m_busy = 0; m_rgb = '0;
    endtask

    task automatic model_step();
        int h, v;
        if (!rstn) begin
            m_run = 0; m_p = 0; m_cnt = '0;
            model_idle();
        end else if (m_run) begin
            h = m_p % HTOT;
            v = m_p / HTOT;
            m_hs = (h < HSW);
            m_vs = (v < VSW);
            m_de = (h >= HSW + HBP) && (h < HSW + HBP + HACT) &&
                   (v >= VSW + VBP) && (v < VSW + VBP + VACT);
            m_rgb = m_de ? ref_rgb(h - HSW - HBP, v - VSW - VBP, m_pat, m_solid) : 30'h0;
            m_busy = 1;
            if (m_p == FRAME - 1) begin
                m_cnt++;
                if (en) begin
                    m_p = 0; m_pat = int'(pat); m_solid = solid;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_p++;
            end
        end else begin
            model_idle();
            if (en) begin
                m_run = 1; m_p = 0; m_pat = int'(pat); m_solid = solid;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("dut0_cycle", {vs0, hs0, de0, r0, g0, b0, busy0, fc0},
            {m_vs, m_hs, m_de, m_rgb, m_busy, m_cnt});
        chk("dut1_cycle", {vs1, hs1, de1, r1, g1, b1, busy1, fc1},
            {~m_vs, ~m_hs, m_de, m_rgb, m_busy, m_cnt});
    endtask

    initial begin
        int hs_n, vs_n, de_n, last_chg, n, p_drop, bad_idle, bad_px;
        bit found, fell;
        logic [15:0] prev_cnt;

        // Reset state
        repeat (3) tick();
        chk("reset_dut0", {vs0, hs0, de0, r0, g0, b0, busy0, fc0}, 64'h0);
        chk("reset_dut1_sync", {vs1, hs1}, 2'b11);
        rstn = 1'b1;
        tick();

        // Three back-to-back colour-bar frames
        pat = 2'd0;
        en  = 1'b1;
        tick();
        hs_n = 0; vs_n = 0; de_n = 0; last_chg = 0; prev_cnt = fc0;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            tick();
            hs_n += int'(hs0);
            vs_n += int'(vs0);
            de_n += int'(de0);
            if (k - 1 >= ACT0 && k - 1 < ACT0 + HACT)
                chk("bar_line", {r0, g0, b0}, bar_line[k - 1 - ACT0]);
            if (fc0 != prev_cnt) begin
                if (last_chg != 0) chk("frame_len", k - last_chg, FRAME);
                last_chg = k;
                prev_cnt = fc0;
            end
        end
        chk("hsync_clocks_3fr", hs_n, 3 * VTOT * HSW);
        chk("vsync_clocks_3fr", vs_n, 3 * VSW * HTOT);
        chk("de_clocks_3fr", de_n, 3 * VACT * HACT);
        chk("frame_cnt_3", fc0, 3);

        // Solid colour frame, switched mid-frame so it lands on the next boundary
        pat   = 2'd3;
        solid = {10'h155, 10'h2AA, 10'h3FF};
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (m_run && m_p == 0 && m_pat == 3) found = 1;
        end
        bad_idle = 0; bad_px = 0; de_n = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (!de0 && {r0, g0, b0} != 30'h0) bad_idle++;
            if (de0 && {r0, g0, b0} != {10'h155, 10'h2AA, 10'h3FF}) bad_px++;
            de_n += int'(de0);
        end
        chk("solid_blank_data", bad_idle, 0);
        chk("solid_pixels", bad_px, 0);
        chk("solid_de_clocks", de_n, VACT * HACT);

        // Drop i_en mid-frame: the frame still completes
        pat = 2'd1;
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            tick();
            if (m_run && m_p == 50) found = 1;
        end
        en = 1'b0;
        p_drop = m_p;
        n = 0; fell = 0;
        for (int i = 0; i < 2 * FRAME && !fell; i++) begin
            tick();
            n++;
            if (!busy0) fell = 1;
        end
        chk("busy_fall", fell, 1);
        chk("drop_len", n, FRAME - p_drop + 1);
        chk("idle_dut0", {vs0, hs0, de0, r0, g0, b0, busy0}, 64'h0);
        chk("idle_dut1_sync", {vs1, hs1, busy1}, 3'b110);
        repeat (4) tick();

        // Ramp frame then random enable / pattern activity
        en = 1'b1;
        repeat (FRAME + 2) tick();
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) begin
                pat   = 2'($urandom_range(0, 3));
                solid = 30'($urandom);
            end
            tick();
        end

        // Asynchronous reset in the middle of an active line
        en  = 1'b1;
        pat = 2'd2;
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            tick();
            if (m_run && m_p == 3 * HTOT + 6) found = 1;
        end
        rstn = 1'b0;
        #1;
        chk("async_rst_dut0", {vs0, hs0, de0, r0, g0, b0, busy0, fc0}, 64'h0);
        chk("async_rst_dut1", {vs1, hs1, de1, busy1, fc1}, {2'b11, 2'b00, 16'h0});
        m_run = 0; m_p = 0; m_cnt = '0;
        model_idle();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("restart_busy", busy0, 1);
        chk("restart_origin_sync", {vs0, hs0, de0}, 3'b110);
        chk("restart_frame_cnt", fc0, 0);
        repeat (FRAME - 1) tick();
        chk("restart_frame_cnt_1", fc0, 1);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
